// File: rtl/debounce_pkg.sv
// Purpose: shared state encoding and width helpers for button debounce logic.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package debounce_pkg;

   // FSM encoding shared by the debouncer and anything that inspects its state
   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } db_state_t;

   // Bits needed to hold values 0..max_val; never returns less than 1
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   // Larger of two integers, used to size the shared repeat counter
   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Purpose: 1-bit two-flop synchronizer for an asynchronous input, reset to 0.
// Latency: 2 clk edges from input change to output change.
// Backpressure: none; free-running.
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   // Shift chain: first stage may go metastable, second stage resolves it
   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   // Both stages clear on reset so no stale level leaks past reset
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/button_debounce_pulse.sv
// Purpose: debounce a raw button, emit one pulse per press (plus optional auto-repeat) and one per release.
// Latency: press/release visible DEBOUNCE_CYCLES+2 edges after the input settles; all outputs registered.
// Backpressure: none; pulses are fire-and-forget single cycles.
module button_debounce_pulse
   import debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_EN       = 0,
   parameter int REPEAT_DELAY    = 16,
   parameter int REPEAT_PERIOD   = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_in,
   output logic btn_level,
   output logic btn_pulse,
   output logic btn_repeat,
   output logic btn_release
);

   localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RPT_W = cnt_width(max2(REPEAT_DELAY, REPEAT_PERIOD));

   // Counters compare against "last sample" values so no extra adder bit is needed
   localparam logic [DB_W-1:0]  DB_ONE         = DB_W'(1);
   localparam logic [DB_W-1:0]  DB_LAST        = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RPT_W-1:0] RPT_ONE        = RPT_W'(1);
   localparam logic [RPT_W-1:0] RPT_DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] RPT_PER_LAST   = RPT_W'(REPEAT_PERIOD - 1);

   logic             s;
   db_state_t        state_q, state_d;
   logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
   logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
   logic             rpt_first_q, rpt_first_d;
   logic             level_q, level_d;
   logic             pulse_q, pulse_d;
   logic             rpt_pulse_q, rpt_pulse_d;
   logic             release_q, release_d;
   logic             press_evt;
   logic             release_evt;
   logic             rpt_evt;
   logic [RPT_W-1:0] rpt_last;

   sync_2ff u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (btn_in),
      .q     (s)
   );

   // State register plus every counter and registered output
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         db_cnt_q    <= '0;
         rpt_cnt_q   <= '0;
         rpt_first_q <= 1'b1;
         level_q     <= 1'b0;
         pulse_q     <= 1'b0;
         rpt_pulse_q <= 1'b0;
         release_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         db_cnt_q    <= db_cnt_d;
         rpt_cnt_q   <= rpt_cnt_d;
         rpt_first_q <= rpt_first_d;
         level_q     <= level_d;
         pulse_q     <= pulse_d;
         rpt_pulse_q <= rpt_pulse_d;
         release_q   <= release_d;
      end
   end

   // Next state: count consecutive agreeing samples, any disagreement aborts the wait
   always_comb begin
      state_d  = state_q;
      db_cnt_d = db_cnt_q;
      unique case (state_q)
         IDLE: begin
            db_cnt_d = '0;
            if (s) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_d = HELD;
               end else begin
                  state_d  = PRESS_WAIT;
                  db_cnt_d = DB_ONE;
               end
            end
         end
         PRESS_WAIT: begin
            if (!s) begin
               state_d  = IDLE;
               db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
               state_d  = HELD;
               db_cnt_d = '0;
            end else begin
               db_cnt_d = db_cnt_q + DB_ONE;
            end
         end
         HELD: begin
            db_cnt_d = '0;
            if (!s) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_d = IDLE;
               end else begin
                  state_d  = RELEASE_WAIT;
                  db_cnt_d = DB_ONE;
               end
            end
         end
         RELEASE_WAIT: begin
            if (s) begin
               state_d  = HELD;
               db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
               state_d  = IDLE;
               db_cnt_d = '0;
            end else begin
               db_cnt_d = db_cnt_q + DB_ONE;
            end
         end
         default: begin
            state_d  = IDLE;
            db_cnt_d = '0;
         end
      endcase
   end

   // Outputs and repeat timer; repeat only advances on HELD cycles that stay high,
   // so a repeat can never coincide with a release in the fast-debounce case
   always_comb begin
      press_evt   = (state_q == IDLE || state_q == PRESS_WAIT) && (state_d == HELD);
      release_evt = (state_q == HELD || state_q == RELEASE_WAIT) && (state_d == IDLE);
      rpt_evt     = 1'b0;
      rpt_cnt_d   = rpt_cnt_q;
      rpt_first_d = rpt_first_q;
      rpt_last    = rpt_first_q ? RPT_DELAY_LAST : RPT_PER_LAST;
      if (press_evt) begin
         rpt_cnt_d   = '0;
         rpt_first_d = 1'b1;
      end else if ((REPEAT_EN != 0) && (state_q == HELD) && s) begin
         if (rpt_cnt_q == rpt_last) begin
            rpt_evt     = 1'b1;
            rpt_cnt_d   = '0;
            rpt_first_d = 1'b0;
         end else begin
            rpt_cnt_d = rpt_cnt_q + RPT_ONE;
         end
      end
      level_d     = (state_d == HELD) || (state_d == RELEASE_WAIT);
      pulse_d     = press_evt | rpt_evt;
      rpt_pulse_d = rpt_evt;
      release_d   = release_evt;
   end

   assign btn_level   = level_q;
   assign btn_pulse   = pulse_q;
   assign btn_repeat  = rpt_pulse_q;
   assign btn_release = release_q;

endmodule

// File: tb/tb_button_debounce_pulse.sv
// Purpose: directed self-checking bench for button_debounce_pulse (repeat off and on instances).
// Latency: expected event cycles derived from the DEBOUNCE_CYCLES+2 press/release latency.
// Backpressure: n/a.
module tb_button_debounce_pulse;

   logic clk = 1'b0;
   logic reset;
   logic btn0, btn1;
   logic l0, p0, r0, rl0;
   logic l1, p1, r1, rl1;

   int cyc = 0;
   int nchk = 0;
   int nerr = 0;
   int rpt_pulses1 = 0;
   int base;
   int pcyc;
   int k0, k1;

   typedef struct {
      int cyc;
      int kind;   // 1 press, 2 repeat, 3 release
   } ev_t;

   ev_t q0[$];
   ev_t q1[$];
   ev_t e0, e1;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   button_debounce_pulse #(
      .DEBOUNCE_CYCLES (4),
      .REPEAT_EN       (0),
      .REPEAT_DELAY    (16),
      .REPEAT_PERIOD   (8)
   ) u0 (
      .clk         (clk),
      .reset       (reset),
      .btn_in      (btn0),
      .btn_level   (l0),
      .btn_pulse   (p0),
      .btn_repeat  (r0),
      .btn_release (rl0)
   );

   button_debounce_pulse #(
      .DEBOUNCE_CYCLES (4),
      .REPEAT_EN       (1),
      .REPEAT_DELAY    (16),
      .REPEAT_PERIOD   (8)
   ) u1 (
      .clk         (clk),
      .reset       (reset),
      .btn_in      (btn1),
      .btn_level   (l1),
      .btn_pulse   (p1),
      .btn_repeat  (r1),
      .btn_release (rl1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Scoreboard for the non-repeating instance
   always @(negedge clk) begin
      if (r0) chk("u0_repeat_disabled", 32'(r0), 0);
      if (p0 || rl0) begin
         chk("u0_pulse_release_excl", 32'(p0 && rl0), 0);
         k0 = rl0 ? 3 : (r0 ? 2 : 1);
         chk("u0_event_expected", 32'(q0.size() > 0), 1);
         if (q0.size() > 0) begin
            e0 = q0.pop_front();
            chk("u0_event_cycle", cyc, e0.cyc);
            chk("u0_event_kind", k0, e0.kind);
         end
      end
   end

   // Scoreboard for the auto-repeat instance
   always @(negedge clk) begin
      if (r1) begin
         chk("u1_repeat_with_pulse", 32'(p1), 1);
         rpt_pulses1++;
      end
      if (p1 || rl1) begin
         chk("u1_pulse_release_excl", 32'(p1 && rl1), 0);
         k1 = rl1 ? 3 : (r1 ? 2 : 1);
         chk("u1_event_expected", 32'(q1.size() > 0), 1);
         if (q1.size() > 0) begin
            e1 = q1.pop_front();
            chk("u1_event_cycle", cyc, e1.cyc);
            chk("u1_event_kind", k1, e1.kind);
         end
      end
   end

   initial begin
      reset = 1'b1;
      btn0  = 1'b0;
      btn1  = 1'b0;
      step(3);
      chk("rst_level0", l0, 0);
      chk("rst_pulse0", p0, 0);
      chk("rst_release0", rl0, 0);
      chk("rst_level1", l1, 0);
      chk("rst_pulse1", p1, 0);
      chk("rst_repeat1", r1, 0);
      reset = 1'b0;
      step(5);

      // Clean press held 60 cycles, then clean release
      base = cyc;
      btn0 = 1'b1;
      q0.push_back('{base + 6, 1});
      step(5);
      chk("s1_level_before", l0, 0);
      step(1);
      chk("s1_level_rise", l0, 1);
      chk("s1_pulse", p0, 1);
      step(1);
      chk("s1_pulse_one_cycle", p0, 0);
      step(53);
      base = cyc;
      btn0 = 1'b0;
      q0.push_back('{base + 6, 3});
      step(5);
      chk("s1_level_hold", l0, 1);
      step(1);
      chk("s1_level_fall", l0, 0);
      chk("s1_release", rl0, 1);
      step(1);
      chk("s1_release_one_cycle", rl0, 0);
      step(5);

      // Glitch of 3 cycles must be ignored
      btn0 = 1'b1;
      step(3);
      btn0 = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step(1);
         chk("s2_glitch_level", l0, 0);
      end

      // Press, then release with a bounce
      base = cyc;
      btn0 = 1'b1;
      q0.push_back('{base + 6, 1});
      step(20);
      base = cyc;
      btn0 = 1'b0;
      step(2);
      btn0 = 1'b1;
      step(1);
      btn0 = 1'b0;
      q0.push_back('{base + 9, 3});
      for (int i = 0; i < 5; i++) begin
         step(1);
         chk("s3_level_through_bounce", l0, 1);
      end
      step(1);
      chk("s3_level_fall", l0, 0);
      step(5);

      // Auto-repeat on the second instance
      base = cyc;
      btn1 = 1'b1;
      pcyc = base + 6;
      q1.push_back('{pcyc, 1});
      for (int k = 0; k < 5; k++) q1.push_back('{pcyc + 16 + 8 * k, 2});
      step(6);
      chk("s4_level_rise", l1, 1);
      step(50);
      btn1 = 1'b0;
      q1.push_back('{pcyc + 56, 3});
      step(10);
      chk("s4_repeat_count", rpt_pulses1, 5);

      // Reset while held with the button still down
      base = cyc;
      btn0 = 1'b1;
      q0.push_back('{base + 6, 1});
      step(10);
      reset = 1'b1;
      step(1);
      chk("s5_rst_level", l0, 0);
      chk("s5_rst_pulse", p0, 0);
      chk("s5_rst_release", rl0, 0);
      reset = 1'b0;
      base = cyc;
      q0.push_back('{base + 6, 1});
      step(5);
      chk("s5_level_before", l0, 0);
      step(1);
      chk("s5_level_rise", l0, 1);
      chk("s5_pulse", p0, 1);
      step(10);
      base = cyc;
      btn0 = 1'b0;
      q0.push_back('{base + 6, 3});
      step(10);

      // Reset while the press debounce counter is at 2
      btn0 = 1'b1;
      step(4);
      reset = 1'b1;
      step(1);
      chk("s6_rst_level", l0, 0);
      reset = 1'b0;
      base = cyc;
      q0.push_back('{base + 6, 1});
      step(5);
      chk("s6_level_before", l0, 0);
      step(1);
      chk("s6_level_rise", l0, 1);
      step(5);
      base = cyc;
      btn0 = 1'b0;
      q0.push_back('{base + 6, 3});
      step(10);

      chk("u0_queue_drained", q0.size(), 0);
      chk("u1_queue_drained", q1.size(), 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/button_debounce_pulse.md
# button_debounce_pulse

Debounces a raw, asynchronous push-button input and converts each clean press into a single-cycle increment pulse, with optional auto-repeat while the button is held. It sits directly upstream of the 4-bit counter (counter_4bit): `btn_pulse` drives the counter's count-enable, so one physical press advances the count by exactly one.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized samples at the same level required to accept a level change; must be ≥1.
- `REPEAT_EN`, default 0: 1 enables auto-repeat while the button is held.
- `REPEAT_DELAY`, default 16: cycles from the initial press pulse to the first repeat pulse; must be ≥1.
- `REPEAT_PERIOD`, default 8: cycles between successive repeat pulses; must be ≥1.

- `clk` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `btn_in` in 1: raw button, asynchronous to `clk`, may bounce.
- `btn_level` out 1: debounced button level.
- `btn_pulse` out 1: one-cycle pulse on each accepted press and on each repeat.
- `btn_repeat` out 1: high only together with `btn_pulse` for repeat pulses.
- `btn_release` out 1: one-cycle pulse on each accepted release.

## Operation
- `btn_in` passes through a 2-flop synchronizer (reset to 0). Its output `s` is the only input the FSM sees.
- The FSM has four states. IDLE, PRESS_WAIT and RELEASE_WAIT each use one debounce counter, sized `$clog2(DEBOUNCE_CYCLES+1)`.
- **IDLE** (`btn_level`=0):
  - `s`=1 → PRESS_WAIT with counter=1.
  - If `DEBOUNCE_CYCLES`=1, go directly to HELD and assert the press pulse.
- **PRESS_WAIT**:
  - `s`=0 → IDLE, counter cleared, no output.
  - `s`=1 → counter++.
  - When the `DEBOUNCE_CYCLES`-th consecutive high sample is taken → HELD. `btn_level`=1 and `btn_pulse`=1 for one cycle.
- **HELD** (`btn_level`=1):
  - `s`=0 → RELEASE_WAIT with counter=1.
  - If `REPEAT_EN`=1, the repeat counter (width fits `max(REPEAT_DELAY, REPEAT_PERIOD)`) runs.
- **RELEASE_WAIT** (`btn_level` stays 1):
  - `s`=1 → back to HELD, with no pulse.
  - After `DEBOUNCE_CYCLES` consecutive low samples → IDLE. `btn_level`=0 and `btn_release`=1 for one cycle.
  - The repeat counter is frozen in this state and resumes on return to HELD.
- **Repeat pulses:**
  - First repeat occurs `REPEAT_DELAY` HELD-cycles after the initial press pulse.
  - Subsequent repeats occur every `REPEAT_PERIOD` HELD-cycles.
  - Each repeat asserts `btn_pulse` and `btn_repeat` for one cycle.
  - The repeat counter clears on entry to HELD from PRESS_WAIT.
- **Output exclusivity:** `btn_pulse` and `btn_release` are never high in the same cycle. Pulses are never longer than one cycle.
- **Reset:**
  - Any cycle with `reset`=1 forces IDLE and clears the synchronizer and all counters.
  - All outputs are 0 in the cycle after the reset edge. No release pulse is generated by reset.
  - A button held through reset is debounced afresh after reset deasserts and yields a new press pulse.

## Timing
- All outputs are registered; none is combinational from `btn_in`.
- **Press latency:** with edge 1 being the first edge that samples `btn_in`=1 (held stable), `btn_level`/`btn_pulse` are high in the cycle after edge `DEBOUNCE_CYCLES+2`. Default: after edge 6.
- **Release latency:** symmetric, `DEBOUNCE_CYCLES+2` edges.
- **Repeat timing:** if the initial pulse is in cycle P and the button stays clean, repeats fall in cycles P+`REPEAT_DELAY`+k·`REPEAT_PERIOD`, for k=0,1,2,…
- A bounce shorter than `DEBOUNCE_CYCLES` synchronized cycles produces no output change.

## Structure
- Shared package `debounce_pkg`:
  - State encoding typedef `db_state_t` with values IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
  - Width-helper constants.
- One sub-module: `sync_2ff` (parameterless 1-bit, 2-flop synchronizer with synchronous reset), reusable by other blocks.
- The FSM and the counters live in `button_debounce_pulse`.

## Test plan
Parameters: `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=16, `REPEAT_PERIOD`=8, 10 ns clock.
- **Clean press, `REPEAT_EN`=0:** `btn_in` 0→1 before edge 1, held 60 cycles → `btn_level` rises after edge 6; exactly one `btn_pulse`; no further pulses.
- **Glitch:** `btn_in` high for 3 cycles, then low → `btn_level`, `btn_pulse` and `btn_release` stay 0 throughout.
- **Release with bounce:** from HELD, `btn_in` gives 2 cycles low, 1 high, then stays low → `btn_level` stays 1 through the bounce; it falls 6 edges after the final low begins; one `btn_release`.
- **Auto-repeat, `REPEAT_EN`=1:** hold for 50 cycles after the initial pulse at cycle P → repeats at P+16, P+24, P+32, P+40, P+48; `btn_repeat` coincides with each; 6 `btn_pulse` total.
- **Reset while HELD with button still held:** all outputs 0 after the reset edge, no `btn_release`; a new `btn_pulse` arrives 6 edges after reset deasserts.
- **Reset in PRESS_WAIT (counter=2):** no pulse; debounce restarts from 0 after reset.
